grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//  Write-back arbiter feeding the single GRF write port. Merges primary W-stage results with late
//  secondary results (MDU / multi-cycle units) buffered in a small FIFO, drives registered
//  RegWrite/A3/RFWD/PC into the GRF, and flags pending writes so D-stage stall logic avoids stale reads.
// PARAMETERS
//  DEPTH   4   secondary FIFO entries (power of two, >=2)
// PORTS
//  Clk             in   1   clock, rising edge
//  Reset           in   1   asynchronous, active-low reset
//  W_RegWrite      in   1   primary write request (always accepted)
//  W_A3            in   5   primary destination register
//  W_WD            in   32  primary write data
//  W_PC            in   32  primary instruction PC
//  M_Valid         in   1   secondary request valid
//  M_Ready         out  1   secondary FIFO can accept
//  M_A3            in   5   secondary destination register
//  M_WD            in   32  secondary write data
//  M_PC            in   32  secondary instruction PC
//  Rd_A1, Rd_A2    in   5   D-stage read addresses for pending check
//  Rd1_Pend        out  1   write to Rd_A1 pending in FIFO or output stage
//  Rd2_Pend        out  1   same for Rd_A2
//  Q_Count         out  $clog2(DEPTH)+1   FIFO occupancy, killed entries included
//  D_GRF_RegWrite  out  1   GRF write enable (registered)
//  D_GRF_A3        out  5   GRF write address (registered)
//  D_GRF_RFWD      out  32  GRF write data (registered)
//  D_GRF_PC        out  32  PC of the write, for tracing (registered)
// BEHAVIOUR
//  - Reset low: FIFO empty, all valid bits 0, Q_Count=0, all D_GRF_* = 0, M_Ready=0.
//    M_Ready=1 from the first cycle after release. Queued entries are lost on reset mid-operation.
//  - M_Ready = Reset & (Q_Count != DEPTH). No same-cycle pop-to-push bypass: when full, M_Ready=0
//    even in a cycle that pops.
//  - Push when M_Valid & M_Ready. Entry holds {valid, A3, WD, PC}. M_A3==0 is accepted and discarded.
//  - Output register, updated each edge, priority order:
//    1. W_RegWrite & W_A3!=0: load primary. Next cycle D_GRF_RegWrite=1 (1-cycle latency).
//    2. Else if FIFO non-empty: pop head. A valid head loads the output with RegWrite=1.
//       A killed head gives RegWrite=0 that cycle.
//    3. Else: D_GRF_RegWrite=0; A3, RFWD and PC hold their values.
//  - Secondary latency is at least 2 edges (enqueue edge, then pop edge). The FIFO has no fall-through.
//  - Kill rule: a primary write (A3!=0) clears the valid bit of every queued entry with the same A3.
//    A secondary push in the same cycle with the same A3 is also dropped, because the primary is the
//    newer result. Killed entries still occupy slots until popped.
//  - Writes to $0 never reach the GRF (D_GRF_RegWrite=0 whenever D_GRF_A3 would be 0).
//  - RdN_Pend (combinational) = (Rd_AN!=0) & (any valid FIFO entry with A3==Rd_AN,
//    or D_GRF_RegWrite & D_GRF_A3==Rd_AN).
//  - Pointers wrap modulo DEPTH. Q_Count changes by +1, -1 or 0 (push and pop in the same cycle).
// CONFIGURATION
//  GRF_WB_TRACE_EN defined: on each rising edge with D_GRF_RegWrite=1, prints
//    $display("%d@%h: $%d <= %h", $time, D_GRF_PC, D_GRF_A3, D_GRF_RFWD).
//  Not defined: no trace code is compiled. Functional behaviour is identical either way.
// TESTING
//  1 Reset=0 mid-traffic -> all D_GRF_*=0, M_Ready=0, Q_Count=0; release -> M_Ready=1 next cycle.
//  2 W_RegWrite=1, W_A3=5, W_WD=32'h1234, W_PC=32'h3000 -> next cycle RegWrite=1, A3=5,
//    RFWD=32'h1234, PC=32'h3000.
//  3 Primary busy every cycle, 5 secondary pushes (A3=1..5) -> 4 accepted, M_Ready=0 on the 5th;
//    primary idles -> writes to 1,2,3,4 in order on consecutive cycles.
//  4 Queue A3=8 WD=0xB, then primary A3=8 WD=0xA -> only 0xA written; popping the killed entry
//    gives RegWrite=0.
//  5 Primary A3=0 -> no write; secondary A3=0 -> handshake completes, no write, Q_Count stays 0.
//  6 Queue A3=3; Rd_A1=3 -> Rd1_Pend=1; Rd_A1=0 -> 0; after the pop issues and retires -> 0.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the GRF write-back arbiter: primary/secondary write requests,
// D-stage pending-read query and the registered GRF write port.
interface grf_wb_arbiter_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          W_RegWrite;
  logic [4:0]    W_A3;
  logic [31:0]   W_WD;
  logic [31:0]   W_PC;
  logic          M_Valid;
  logic          M_Ready;
  logic [4:0]    M_A3;
  logic [31:0]   M_WD;
  logic [31:0]   M_PC;
  logic [4:0]    Rd_A1;
  logic [4:0]    Rd_A2;
  logic          Rd1_Pend;
  logic          Rd2_Pend;
  logic [CW-1:0] Q_Count;
  logic          D_GRF_RegWrite;
  logic [4:0]    D_GRF_A3;
  logic [31:0]   D_GRF_RFWD;
  logic [31:0]   D_GRF_PC;

  modport master (
    output W_RegWrite, W_A3, W_WD, W_PC,
    output M_Valid, M_A3, M_WD, M_PC,
    output Rd_A1, Rd_A2,
    input  M_Ready, Rd1_Pend, Rd2_Pend, Q_Count,
    input  D_GRF_RegWrite, D_GRF_A3, D_GRF_RFWD, D_GRF_PC
  );

  modport slave (
    input  W_RegWrite, W_A3, W_WD, W_PC,
    input  M_Valid, M_A3, M_WD, M_PC,
    input  Rd_A1, Rd_A2,
    output M_Ready, Rd1_Pend, Rd2_Pend, Q_Count,
    output D_GRF_RegWrite, D_GRF_A3, D_GRF_RFWD, D_GRF_PC
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter: primary W-stage writes win, late secondary results drain from a FIFO.
// Define GRF_WB_TRACE_EN to print every retired GRF write.
module grf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input logic             Clk,
  input logic             Reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          q_valid [DEPTH];
  logic [4:0]    q_a3    [DEPTH];
  logic [31:0]   q_wd    [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          out_we;
  logic [4:0]    out_a3;
  logic [31:0]   out_wd;
  logic [31:0]   out_pc;

  logic prim_wr;
  logic push;
  logic enq;
  logic enq_valid;
  logic pop;
  logic hit1;
  logic hit2;

  assign prim_wr   = bus.W_RegWrite & (bus.W_A3 != 5'd0);
  assign bus.M_Ready = Reset & (count != FULL);
  assign push      = bus.M_Valid & bus.M_Ready;
  // $0 pushes complete the handshake but never occupy a slot
  assign enq       = push & (bus.M_A3 != 5'd0);
  assign enq_valid = ~(prim_wr & (bus.W_A3 == bus.M_A3));
  assign pop       = ~prim_wr & (count != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_a3[i]    <= 5'd0;
        q_wd[i]    <= 32'd0;
        q_pc[i]    <= 32'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // A newer primary result makes any queued write to the same register stale
      for (int i = 0; i < DEPTH; i++) begin
        if (prim_wr && q_a3[i] == bus.W_A3) q_valid[i] <= 1'b0;
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (enq) begin
        q_valid[wr_ptr] <= enq_valid;
        q_a3[wr_ptr]    <= bus.M_A3;
        q_wd[wr_ptr]    <= bus.M_WD;
        q_pc[wr_ptr]    <= bus.M_PC;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_we <= 1'b0;
      out_a3 <= 5'd0;
      out_wd <= 32'd0;
      out_pc <= 32'd0;
    end else if (prim_wr) begin
      out_we <= 1'b1;
      out_a3 <= bus.W_A3;
      out_wd <= bus.W_WD;
      out_pc <= bus.W_PC;
    end else if (pop) begin
      out_we <= q_valid[rd_ptr];
      if (q_valid[rd_ptr]) begin
        out_a3 <= q_a3[rd_ptr];
        out_wd <= q_wd[rd_ptr];
        out_pc <= q_pc[rd_ptr];
      end
    end else begin
      out_we <= 1'b0;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && q_a3[i] == bus.Rd_A1) hit1 = 1'b1;
      if (q_valid[i] && q_a3[i] == bus.Rd_A2) hit2 = 1'b1;
    end
  end

  assign bus.Rd1_Pend = (bus.Rd_A1 != 5'd0) & (hit1 | (out_we & (out_a3 == bus.Rd_A1)));
  assign bus.Rd2_Pend = (bus.Rd_A2 != 5'd0) & (hit2 | (out_we & (out_a3 == bus.Rd_A2)));

  assign bus.Q_Count        = count;
  assign bus.D_GRF_RegWrite = out_we;
  assign bus.D_GRF_A3       = out_a3;
  assign bus.D_GRF_RFWD     = out_wd;
  assign bus.D_GRF_PC       = out_pc;

`ifdef GRF_WB_TRACE_EN
  always @(posedge Clk) begin
    if (out_we) $display("%d@%h: $%d <= %h", $time, out_pc, out_a3, out_wd);
  end
`else
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed, table-driven bench for grf_wb_arbiter plus hand-written reset and pending sequences.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct {
    logic          w_we;
    logic [4:0]    w_a3;
    logic [31:0]   w_wd;
    logic [31:0]   w_pc;
    logic          m_valid;
    logic [4:0]    m_a3;
    logic [31:0]   m_wd;
    logic [31:0]   m_pc;
    logic [4:0]    rd1;
    logic [4:0]    rd2;
    logic          e_rw;
    logic [4:0]    e_a3;
    logic [31:0]   e_wd;
    logic [31:0]   e_pc;
    logic [CW-1:0] e_q;
    logic          chk_q;
    logic          e_ready;
    logic          e_p1;
    logic          e_p2;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   passCount = 0;
  int   checkCount = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  grf_wb_arbiter_if #(.DEPTH(DEPTH)) bus();

  grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  function automatic vec_t mkVec(
    input logic w_we, input logic [4:0] w_a3, input logic [31:0] w_wd, input logic [31:0] w_pc,
    input logic m_valid, input logic [4:0] m_a3, input logic [31:0] m_wd, input logic [31:0] m_pc,
    input logic [4:0] rd1, input logic [4:0] rd2,
    input logic e_rw, input logic [4:0] e_a3, input logic [31:0] e_wd, input logic [31:0] e_pc,
    input logic [CW-1:0] e_q, input logic chk_q, input logic e_ready, input logic e_p1,
    input logic e_p2);
    vec_t v;
    v.w_we = w_we;  v.w_a3 = w_a3;  v.w_wd = w_wd;  v.w_pc = w_pc;
    v.m_valid = m_valid;  v.m_a3 = m_a3;  v.m_wd = m_wd;  v.m_pc = m_pc;
    v.rd1 = rd1;  v.rd2 = rd2;
    v.e_rw = e_rw;  v.e_a3 = e_a3;  v.e_wd = e_wd;  v.e_pc = e_pc;
    v.e_q = e_q;  v.chk_q = chk_q;  v.e_ready = e_ready;  v.e_p1 = e_p1;  v.e_p2 = e_p2;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.W_RegWrite = v.w_we;
    bus.W_A3       = v.w_a3;
    bus.W_WD       = v.w_wd;
    bus.W_PC       = v.w_pc;
    bus.M_Valid    = v.m_valid;
    bus.M_A3       = v.m_a3;
    bus.M_WD       = v.m_wd;
    bus.M_PC       = v.m_pc;
    bus.Rd_A1      = v.rd1;
    bus.Rd_A2      = v.rd2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    checkOutput($sformatf("v%0d.regwrite", idx), 32'(bus.D_GRF_RegWrite), 32'(v.e_rw));
    checkOutput($sformatf("v%0d.a3", idx), 32'(bus.D_GRF_A3), 32'(v.e_a3));
    checkOutput($sformatf("v%0d.rfwd", idx), bus.D_GRF_RFWD, v.e_wd);
    checkOutput($sformatf("v%0d.pc", idx), bus.D_GRF_PC, v.e_pc);
    if (v.chk_q) checkOutput($sformatf("v%0d.qcount", idx), 32'(bus.Q_Count), 32'(v.e_q));
    checkOutput($sformatf("v%0d.ready", idx), 32'(bus.M_Ready), 32'(v.e_ready));
    checkOutput($sformatf("v%0d.pend1", idx), 32'(bus.Rd1_Pend), 32'(v.e_p1));
    checkOutput($sformatf("v%0d.pend2", idx), 32'(bus.Rd2_Pend), 32'(v.e_p2));
  endtask

  task automatic idleInputs();
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // Each row: inputs held across one rising edge, expected outputs just after it
    // primary write, then idle
    vecs.push_back(mkVec(1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 5, 0,   1, 5, 32'h1234, 32'h3000, 0, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 5, 0,                 0, 5, 32'h1234, 32'h3000, 0, 1, 1, 0, 0));
    // primary busy while secondary fills the FIFO; fifth push refused
    vecs.push_back(mkVec(1, 20, 32'h20, 32'h400, 1, 1, 32'h101, 32'h201, 1, 20, 1, 20, 32'h20, 32'h400, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 21, 32'h21, 32'h404, 1, 2, 32'h102, 32'h202, 2, 0,  1, 21, 32'h21, 32'h404, 2, 1, 1, 1, 0));
    vecs.push_back(mkVec(1, 22, 32'h22, 32'h408, 1, 3, 32'h103, 32'h203, 3, 22, 1, 22, 32'h22, 32'h408, 3, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 23, 32'h23, 32'h40c, 1, 4, 32'h104, 32'h204, 1, 0,  1, 23, 32'h23, 32'h40c, 4, 1, 0, 1, 0));
    vecs.push_back(mkVec(1, 24, 32'h24, 32'h410, 1, 5, 32'h105, 32'h205, 5, 4,  1, 24, 32'h24, 32'h410, 4, 1, 0, 0, 1));
    // drain in order
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h101, 32'h201, 3, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 32'h102, 32'h202, 2, 1, 1, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 3, 32'h103, 32'h203, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 4, 32'h104, 32'h204, 0, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 4, 32'h104, 32'h204, 0, 1, 1, 0, 0));
    // push and pop in the same cycle
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 6, 32'h106, 32'h206, 6, 0, 0, 4, 32'h104, 32'h204, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 7, 32'h107, 32'h207, 6, 7, 1, 6, 32'h106, 32'h206, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 6, 7,             1, 7, 32'h107, 32'h207, 0, 1, 1, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 7, 32'h107, 32'h207, 0, 1, 1, 0, 0));
    // queued $8 killed by a newer primary write; popping it writes nothing
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 8, 32'hB, 32'h208, 8, 0,   0, 7, 32'h107, 32'h207, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(1, 8, 32'hA, 32'h300, 0, 0, 0, 0, 8, 0,   1, 8, 32'hA, 32'h300, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 8, 0,             0, 8, 32'hA, 32'h300, 0, 1, 1, 0, 0));
    // $0 writes on both paths vanish
    vecs.push_back(mkVec(1, 0, 32'hDEAD, 32'h500, 1, 0, 32'hBEEF, 32'h501, 0, 0, 0, 8, 32'hA, 32'h300, 0, 1, 1, 0, 0));
    // same-cycle primary and secondary to $9: primary wins, secondary never written
    vecs.push_back(mkVec(1, 9, 32'h99, 32'h600, 1, 9, 32'h77, 32'h601, 9, 0, 1, 9, 32'h99, 32'h600, 0, 0, 1, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 9, 0,             0, 9, 32'h99, 32'h600, 0, 1, 1, 0, 0));
    // queue $3 for the pending-read sequence
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 3, 32'h33, 32'h700, 3, 0,  0, 9, 32'h99, 32'h600, 1, 1, 1, 1, 0));

    Reset = 1'b0;
    idleInputs();
    #12;
    checkOutput("reset.regwrite", 32'(bus.D_GRF_RegWrite), 32'd0);
    checkOutput("reset.a3", 32'(bus.D_GRF_A3), 32'd0);
    checkOutput("reset.rfwd", bus.D_GRF_RFWD, 32'd0);
    checkOutput("reset.pc", bus.D_GRF_PC, 32'd0);
    checkOutput("reset.qcount", 32'(bus.Q_Count), 32'd0);
    checkOutput("reset.ready", 32'(bus.M_Ready), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("release.ready", 32'(bus.M_Ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      applyStimulus(vecs[i]);
      @(posedge Clk);
      #1;
      checkVector(vecs[i], i);
    end

    // Pending flag follows Rd_A1 combinationally, then clears once the write retires
    bus.M_Valid = 1'b0;
    bus.Rd_A1 = 5'd0;
    #1;
    checkOutput("pend.rd0", 32'(bus.Rd1_Pend), 32'd0);
    bus.Rd_A1 = 5'd3;
    #1;
    checkOutput("pend.queued", 32'(bus.Rd1_Pend), 32'd1);
    @(negedge Clk);
    idleInputs();
    bus.Rd_A1 = 5'd3;
    @(posedge Clk);
    #1;
    checkOutput("pend.issue.regwrite", 32'(bus.D_GRF_RegWrite), 32'd1);
    checkOutput("pend.issue.a3", 32'(bus.D_GRF_A3), 32'd3);
    checkOutput("pend.issue.rfwd", bus.D_GRF_RFWD, 32'h33);
    checkOutput("pend.issue.pc", bus.D_GRF_PC, 32'h700);
    checkOutput("pend.issue", 32'(bus.Rd1_Pend), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput("pend.retired.regwrite", 32'(bus.D_GRF_RegWrite), 32'd0);
    checkOutput("pend.retired", 32'(bus.Rd1_Pend), 32'd0);

    // Reset mid-traffic drops the queue and clears the output stage
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      applyStimulus(mkVec(1, 5'(20 + k), 32'(k), 32'h800, 1, 5'(10 + k), 32'hC0, 32'h900,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(posedge Clk);
    #2;
    checkOutput("midreset.pre.qcount", 32'(bus.Q_Count), 32'd3);
    Reset = 1'b0;
    #1;
    checkOutput("midreset.regwrite", 32'(bus.D_GRF_RegWrite), 32'd0);
    checkOutput("midreset.a3", 32'(bus.D_GRF_A3), 32'd0);
    checkOutput("midreset.rfwd", bus.D_GRF_RFWD, 32'd0);
    checkOutput("midreset.pc", bus.D_GRF_PC, 32'd0);
    checkOutput("midreset.qcount", 32'(bus.Q_Count), 32'd0);
    checkOutput("midreset.ready", 32'(bus.M_Ready), 32'd0);
    @(negedge Clk);
    idleInputs();
    bus.Rd_A1 = 5'd10;
    Reset = 1'b1;
    #1;
    checkOutput("midrelease.ready", 32'(bus.M_Ready), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput("midrelease.regwrite", 32'(bus.D_GRF_RegWrite), 32'd0);
    checkOutput("midrelease.qcount", 32'(bus.Q_Count), 32'd0);
    checkOutput("midrelease.pend", 32'(bus.Rd1_Pend), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
